// File: rtl/vga_rect_renderer.sv
// vga_rect_renderer
// Colours each pixel from vga_timing_gen by testing it against a small bank of
// axis-aligned rectangles. The host loads a shadow bank through a valid/ready
// port and requests a commit. The shadow bank is copied into the live bank at
// the next frame boundary (x == 0, y == 480), so no frame shows a half-updated
// scene.
// Output: a 2-cycle pipelined RGB222 pixel. hs/vs/de are delayed by the same
// amount so they stay aligned with rgb.
// Optional feature: define RECT_OUTLINE_EN to build per-slot outline storage.
// With it set, a slot hits only on its one-pixel border.

module vga_rect_renderer #(
  parameter int NUM_RECTS = 4,
  parameter int COLOR_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               active,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_idx,
  input  logic [2:0]         wr_field,
  input  logic [9:0]         wr_data,
  input  logic               commit,
  output logic               commit_pending,
  input  logic [COLOR_W-1:0] bg_color,
  output logic [COLOR_W-1:0] rgb,
  output logic               hs_out,
  output logic               vs_out,
  output logic               de_out
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t state_reg;

  // Shadow bank, written by the host
  logic [9:0]         sh_x0    [NUM_RECTS];
  logic [9:0]         sh_y0    [NUM_RECTS];
  logic [9:0]         sh_x1    [NUM_RECTS];
  logic [9:0]         sh_y1    [NUM_RECTS];
  logic [COLOR_W-1:0] sh_color [NUM_RECTS];
  logic               sh_en    [NUM_RECTS];

  // Live bank, read by the hit test
  logic [9:0]         lv_x0    [NUM_RECTS];
  logic [9:0]         lv_y0    [NUM_RECTS];
  logic [9:0]         lv_x1    [NUM_RECTS];
  logic [9:0]         lv_y1    [NUM_RECTS];
  logic [COLOR_W-1:0] lv_color [NUM_RECTS];
  logic               lv_en    [NUM_RECTS];

`ifdef RECT_OUTLINE_EN
  logic               sh_outline [NUM_RECTS];
  logic               lv_outline [NUM_RECTS];
`endif

  logic                 frame_boundary;
  logic                 wr_accept;
  logic                 apply_commit;
  logic [NUM_RECTS-1:0] hit_comb;

  // Pipeline stage 1 registers
  logic [NUM_RECTS-1:0] hit_reg;
  logic                 de_s1_reg;
  logic                 hs_s1_reg;
  logic                 vs_s1_reg;

  logic [COLOR_W-1:0]   pix_next;

  assign frame_boundary = (x == 10'd0) && (y == 10'd480);
  assign wr_accept      = wr_valid && wr_ready;
  assign apply_commit   = (state_reg == PENDING) && frame_boundary;

  // Commit handshake: IDLE -> PENDING on commit, PENDING -> IDLE at the frame
  // boundary. Outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      commit_pending <= 1'b0;
      wr_ready       <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (commit) begin
            state_reg      <= PENDING;
            commit_pending <= 1'b1;
            wr_ready       <= 1'b0;
          end
        end
        PENDING: begin
          if (frame_boundary) begin
            state_reg      <= IDLE;
            commit_pending <= 1'b0;
            wr_ready       <= 1'b1;
          end
        end
        default: begin
          state_reg      <= IDLE;
          commit_pending <= 1'b0;
          wr_ready       <= 1'b1;
        end
      endcase
    end
  end

  // Host writes into the shadow bank. An out-of-range slot matches no
  // iteration, so the write is dropped. Field 7 is also dropped, and so is
  // field 6 when no outline storage is built.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        sh_x0[i]    <= '0;
        sh_y0[i]    <= '0;
        sh_x1[i]    <= '0;
        sh_y1[i]    <= '0;
        sh_color[i] <= '0;
        sh_en[i]    <= 1'b0;
`ifdef RECT_OUTLINE_EN
        sh_outline[i] <= 1'b0;
`endif
      end
    end else begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (wr_accept && (wr_idx == 3'(i))) begin
          case (wr_field)
            3'd0: sh_x0[i]    <= wr_data;
            3'd1: sh_y0[i]    <= wr_data;
            3'd2: sh_x1[i]    <= wr_data;
            3'd3: sh_y1[i]    <= wr_data;
            3'd4: sh_color[i] <= wr_data[COLOR_W-1:0];
            3'd5: sh_en[i]    <= wr_data[0];
`ifdef RECT_OUTLINE_EN
            3'd6: sh_outline[i] <= wr_data[0];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Publish the shadow bank only at the first cycle of vertical blanking.
  // No write can coincide with this copy, because wr_ready is low while a
  // commit is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        lv_x0[i]    <= '0;
        lv_y0[i]    <= '0;
        lv_x1[i]    <= '0;
        lv_y1[i]    <= '0;
        lv_color[i] <= '0;
        lv_en[i]    <= 1'b0;
`ifdef RECT_OUTLINE_EN
        lv_outline[i] <= 1'b0;
`endif
      end
    end else if (apply_commit) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        lv_x0[i]    <= sh_x0[i];
        lv_y0[i]    <= sh_y0[i];
        lv_x1[i]    <= sh_x1[i];
        lv_y1[i]    <= sh_y1[i];
        lv_color[i] <= sh_color[i];
        lv_en[i]    <= sh_en[i];
`ifdef RECT_OUTLINE_EN
        lv_outline[i] <= sh_outline[i];
`endif
      end
    end
  end

  // Per-slot hit test against the live bank.
  // Half-open intervals make x1 <= x0 or y1 <= y0 an empty box.
  generate
    for (genvar gi = 0; gi < NUM_RECTS; gi++) begin : g_slot
      logic in_x;
      logic in_y;
      assign in_x = (x >= lv_x0[gi]) && (x < lv_x1[gi]);
      assign in_y = (y >= lv_y0[gi]) && (y < lv_y1[gi]);
`ifdef RECT_OUTLINE_EN
      logic on_border;
      assign on_border = (x == lv_x0[gi]) || (x == lv_x1[gi] - 10'd1) ||
                         (y == lv_y0[gi]) || (y == lv_y1[gi] - 10'd1);
      assign hit_comb[gi] = lv_en[gi] && in_x && in_y &&
                            (!lv_outline[gi] || on_border);
`else
      assign hit_comb[gi] = lv_en[gi] && in_x && in_y;
`endif
    end
  endgenerate

  // Stage 1: register the hit vector and the delayed timing signals.
  // Sync outputs reset to their inactive (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_reg   <= '0;
      de_s1_reg <= 1'b0;
      hs_s1_reg <= 1'b1;
      vs_s1_reg <= 1'b1;
    end else begin
      hit_reg   <= hit_comb;
      de_s1_reg <= active;
      hs_s1_reg <= hs_in;
      vs_s1_reg <= vs_in;
    end
  end

  // Priority mux: the scan runs from the highest slot down, so the lowest hitting
  // index is assigned last and wins. Blanking forces black.
  // lv_color is read here rather than carried through stage 1. It can only
  // change at the boundary cycle, and that pixel and its neighbours are blanked.
  always_comb begin
    pix_next = bg_color;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit_reg[i]) pix_next = lv_color[i];
    end
    if (!de_s1_reg) pix_next = '0;
  end

  // Stage 2: output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb    <= '0;
      de_out <= 1'b0;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
    end else begin
      rgb    <= pix_next;
      de_out <= de_s1_reg;
      hs_out <= hs_s1_reg;
      vs_out <= vs_s1_reg;
    end
  end

endmodule

// File: doc/vga_rect_renderer.md
# vga_rect_renderer

Downstream consumer of `vga_timing_gen`: takes its `x`/`y`/`active`/`hs`/`vs` stream and produces per-pixel colour by testing the pixel against a small bank of axis-aligned filled rectangles.
- Host-side logic (SPI/Arduino command decoder) loads rectangle parameters into a shadow bank through a valid/ready write port.
- The shadow bank is copied into the live bank only at a frame boundary, so a frame never shows a half-updated scene.
- Output is a 2-cycle-pipelined RGB222 pixel with sync/data-enable delayed to match.

## Interface
- `NUM_RECTS`, 4: number of rectangle slots (1..8); slot 0 has highest priority.
- `COLOR_W`, 6: colour width, RRGGBB.
- `clk` in 1: pixel clock (25.175 MHz nominal).
- `rst_n` in 1: asynchronous, active-low reset.
- `x` in 10: current column from `vga_timing_gen`.
- `y` in 10: current row from `vga_timing_gen`.
- `active` in 1: visible-region flag from `vga_timing_gen`.
- `hs_in` in 1: horizontal sync, active-low.
- `vs_in` in 1: vertical sync, active-low.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when high together with `wr_valid`.
- `wr_idx` in 3: slot index.
- `wr_field` in 3: field select. 0 = x0, 1 = y0, 2 = x1, 3 = y1, 4 = colour (low `COLOR_W` bits), 5 = enable (bit 0), 6 = outline (bit 0).
- `wr_data` in 10: field value.
- `commit` in 1: single-cycle request to publish the shadow bank.
- `commit_pending` out 1: commit requested, not yet applied.
- `bg_color` in `COLOR_W`: colour for active pixels hit by no rectangle.
- `rgb` out `COLOR_W`: pixel colour.
- `hs_out` out 1: `hs_in` delayed 2 cycles.
- `vs_out` out 1: `vs_in` delayed 2 cycles.
- `de_out` out 1: `active` delayed 2 cycles.

## Operation
**Writes**
- `wr_ready` = !`commit_pending`.
- On `wr_valid && wr_ready`, the selected shadow field is loaded.
- Writes are accepted and silently dropped when `wr_idx >= NUM_RECTS` or `wr_field == 7`.

**Commit**
- `commit` high while `commit_pending` = 0 sets `commit_pending` at the next edge.
- `commit` while already pending has no effect.
- A write and `commit` in the same cycle: the write lands in the shadow bank and is included in that commit.

**Frame boundary**
- Defined as the cycle with `x == 0 && y == 480` (first cycle of vertical blanking).
- If `commit_pending` = 1 at the frame boundary: live bank <= shadow bank, `commit_pending` <= 0.
- A commit request arriving on the boundary cycle itself sets pending and waits for the next frame.

**Hit test (live bank)**
- Rectangle i hits when enabled, `x0 <= x < x1` and `y0 <= y < y1`, with 10-bit unsigned compares.
- `x1 <= x0` or `y1 <= y0` means an empty rectangle that never hits.
- Coordinates ≥ 640/480 are legal and simply clip.

**Priority**
- The lowest-index hitting slot supplies `rgb`.
- No hit gives `bg_color`.
- `de_out` = 0 forces `rgb` = 0.

**States**
- The only control state is `commit_pending`: IDLE (0) -> PENDING (1) on commit; PENDING -> IDLE on frame boundary.

## Timing
- **Pipeline stage 1:** register per-slot hit vector plus delayed `active`/`hs`/`vs`.
- **Pipeline stage 2:** priority mux into `rgb`, `de_out`, `hs_out`, `vs_out`.
- **Latency:** exactly 2 clocks from `x`/`y`/`active` to `rgb`/`de_out`; sync outputs stay aligned with `rgb`.
- **Reset values:**
  - `rgb` = 0, `de_out` = 0.
  - `hs_out` = 1, `vs_out` = 1 (inactive).
  - `commit_pending` = 0, so `wr_ready` = 1 out of reset.
  - All shadow and live fields are 0, so every slot is disabled.
- **Reset mid-frame:** outputs return to reset values immediately. Scene is lost; the host must reload and commit.
- The live bank changes only on the frame-boundary edge. A rectangle's state is constant for every visible pixel of a frame.

## Configuration
- **`RECT_OUTLINE_EN` defined:** field 6 stores a per-slot outline bit. When it is set, slot i hits only on its border: `x == x0`, `x == x1-1`, `y == y0` or `y == y1-1`, inside the box. Interior pixels fall through to lower-priority slots or `bg_color`.
- **`RECT_OUTLINE_EN` undefined:** field 6 writes are accepted and dropped; all rectangles are filled. No outline storage is built.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles, then release. Expect `rgb` = 0, `hs_out`/`vs_out` = 1, `wr_ready` = 1, then `rgb` == `bg_color` (0x15) on every visible pixel of frame 1.
- **Single rectangle:** slot 0 = (100, 50, 200, 150), colour 0x30, enabled, commit. Next frame: pixel (100, 50) gives 0x30 two cycles after it is presented. (99, 50), (200, 50) and (100, 150) give `bg_color`.
- **Priority:** slot 0 = (0, 0, 64, 64) colour 0x03, slot 1 = (32, 32, 96, 96) colour 0x0C. Pixel (40, 40) gives 0x03; (80, 80) gives 0x0C.
- **Commit handshake:** commit at y = 200. Expect `commit_pending` = 1 and `wr_ready` = 0 until the edge at (0, 480), then both clear. A write attempted while pending is not accepted, and the live frame is unchanged until the boundary.
- **Boundary/edge cases:** write to `wr_idx` = 5 (NUM_RECTS = 4) gives no effect. Rectangle with x1 = x0 = 300 never hits. Commit on the boundary cycle applies one frame later.
- **`RECT_OUTLINE_EN`:** outline on slot 0 = (10, 10, 20, 20). Pixel (10, 15) gives the slot colour; (15, 15) gives `bg_color`. With the macro undefined, (15, 15) gives the slot colour.
